// File: rtl/fc_rx_framer.sv
// fc_rx_framer
//   Fibre Channel receive framer. Classifies 32-bit PHY words as ordered sets,
//   data or invalid, acquires word lock, and extracts SOF..EOF frames onto an
//   Avalon-ST source without backpressure. Each data word is held for one cycle
//   so the word before EOF can be emitted with endofpacket set.
//
// Ports
//   clk               PHY receive clock, rising edge
//   reset             synchronous, active-high
//   rx_data/rx_datak  PHY word and per-byte K-flags (byte 0 first on the line)
//   rx_sync           PHY word sync
//   out_data          frame word (header, payload, CRC)
//   out_valid/out_startofpacket/out_endofpacket/out_error  stream qualifiers
//   r_rdy             one-cycle pulse per received R_RDY
//   frame_ok_count/frame_err_count  saturating frame counters
module fc_rx_framer #(
    parameter int unsigned MAX_WORDS = 537
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_datak,
    input  logic        rx_sync,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic        out_error,
    output logic        r_rdy,
    output logic [15:0] frame_ok_count,
    output logic [15:0] frame_err_count
);

    localparam int unsigned WCW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        ST_LOS,
        ST_HUNT,
        ST_IDLE,
        ST_FRAME,
        ST_DISCARD
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      hunt_cnt_q, hunt_cnt_d;
    logic [31:0]     held_q, held_d;
    logic            held_vld_q, held_vld_d;
    logic            first_q, first_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [31:0]     out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_sop_q, out_sop_d;
    logic            out_eop_q, out_eop_d;
    logic            out_err_q, out_err_d;
    logic            r_rdy_q, r_rdy_d;
    logic [15:0]     ok_q, ok_d;
    logic [15:0]     errc_q, errc_d;

    // Word classification
    logic [7:0] b1, b2, b3;
    logic       is_os, is_data, is_sof, is_eof, is_eof_good, is_rrdy;

    always_comb begin
        b1          = rx_data[15:8];
        b2          = rx_data[23:16];
        b3          = rx_data[31:24];
        is_os       = (rx_datak == 4'b0001) && (rx_data[7:0] == 8'hBC);
        is_data     = (rx_datak == 4'b0000);
        is_sof      = is_os && (b1 == 8'hB5) && (b2 == b3) &&
                      ((b2 == 8'h56) || (b2 == 8'h36) || (b2 == 8'h58));
        is_eof      = is_os && ((b1 == 8'h95) || (b1 == 8'hB5)) && (b2 == b3) &&
                      ((b2 == 8'h75) || (b2 == 8'hD5) || (b2 == 8'hF5));
        is_eof_good = is_eof && (b2 != 8'hF5);
        is_rrdy     = is_os && (rx_data == 32'h4A4A95BC);
    end

    logic close, close_good;

    always_comb begin
        state_d     = state_q;
        hunt_cnt_d  = hunt_cnt_q;
        held_d      = held_q;
        held_vld_d  = held_vld_q;
        first_d     = first_q;
        wcnt_d      = wcnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
        out_err_d   = 1'b0;
        r_rdy_d     = 1'b0;
        ok_d        = ok_q;
        errc_d      = errc_q;
        close       = 1'b0;
        close_good  = 1'b0;

        if (!rx_sync) begin
            close   = (state_q == ST_FRAME);
            state_d = ST_LOS;
        end else begin
            r_rdy_d = is_rrdy && ((state_q == ST_IDLE) || (state_q == ST_FRAME) ||
                                  (state_q == ST_DISCARD));
            unique case (state_q)
                ST_LOS: begin
                    state_d    = ST_HUNT;
                    hunt_cnt_d = '0;
                end
                ST_HUNT: begin
                    if (is_os) begin
                        if (hunt_cnt_q == 2'd2) begin
                            state_d = ST_IDLE;
                        end else begin
                            hunt_cnt_d = hunt_cnt_q + 2'd1;
                        end
                    end else begin
                        hunt_cnt_d = '0;
                    end
                end
                ST_IDLE: begin
                    if (is_sof) begin
                        state_d    = ST_FRAME;
                        held_vld_d = 1'b0;
                        first_d    = 1'b1;
                        wcnt_d     = '0;
                    end
                end
                ST_FRAME: begin
                    if (is_data) begin
                        if (wcnt_q == WCW'(MAX_WORDS)) begin
                            close   = 1'b1;
                            state_d = ST_DISCARD;
                        end else begin
                            if (held_vld_q) begin
                                out_valid_d = 1'b1;
                                out_data_d  = held_q;
                                out_sop_d   = first_q;
                                first_d     = 1'b0;
                            end
                            held_d     = rx_data;
                            held_vld_d = 1'b1;
                            wcnt_d     = wcnt_q + WCW'(1);
                        end
                    end else if (is_sof) begin
                        // Close the running frame and open the new one in place.
                        close      = 1'b1;
                        first_d    = 1'b1;
                        wcnt_d     = '0;
                    end else begin
                        close      = 1'b1;
                        close_good = is_eof_good;
                        state_d    = ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (is_os) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_LOS;
            endcase
        end

        // Frame termination: flush the held word with eop, then count the frame.
        // A good EOF with nothing held still counts as an errored frame.
        if (close) begin
            if (held_vld_q) begin
                out_valid_d = 1'b1;
                out_data_d  = held_q;
                out_sop_d   = first_q;
                out_eop_d   = 1'b1;
                out_err_d   = !close_good;
            end
            held_vld_d = 1'b0;
            if (close_good && held_vld_q) begin
                if (ok_q != '1) ok_d = ok_q + 16'd1;
            end else begin
                if (errc_q != '1) errc_d = errc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOS;
            hunt_cnt_q  <= '0;
            held_q      <= '0;
            held_vld_q  <= 1'b0;
            first_q     <= 1'b0;
            wcnt_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_err_q   <= 1'b0;
            r_rdy_q     <= 1'b0;
            ok_q        <= '0;
            errc_q      <= '0;
        end else begin
            state_q     <= state_d;
            hunt_cnt_q  <= hunt_cnt_d;
            held_q      <= held_d;
            held_vld_q  <= held_vld_d;
            first_q     <= first_d;
            wcnt_q      <= wcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_err_q   <= out_err_d;
            r_rdy_q     <= r_rdy_d;
            ok_q        <= ok_d;
            errc_q      <= errc_d;
        end
    end

    assign out_data          = out_data_q;
    assign out_valid         = out_valid_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign out_error         = out_err_q;
    assign r_rdy             = r_rdy_q;
    assign frame_ok_count    = ok_q;
    assign frame_err_count   = errc_q;

endmodule

// File: tb/tb_fc_rx_framer.sv
// tb_fc_rx_framer
//   Directed stimulus for fc_rx_framer. A stream-level model predicts the
//   registered outputs after every clock; a single compare process checks them,
//   and literal checks after each scenario pin the model against hand values.
module tb_fc_rx_framer;

    localparam int MAXW = 537;

    localparam logic [31:0] W_IDLE = 32'hB5B595BC;
    localparam logic [31:0] W_RRDY = 32'h4A4A95BC;
    localparam logic [31:0] W_SOF  = 32'h5656B5BC;
    localparam logic [31:0] W_EOFT = 32'h757595BC;
    localparam logic [31:0] W_EOFN = 32'hD5D595BC;
    localparam logic [31:0] W_EOFA = 32'hF5F595BC;
    localparam logic [31:0] W_OTH  = 32'hE0E095BC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rx_data = '0;
    logic [3:0]  rx_datak = '0;
    logic        rx_sync = 1'b0;
    logic [31:0] out_data;
    logic        out_valid, out_startofpacket, out_endofpacket, out_error, r_rdy;
    logic [15:0] frame_ok_count, frame_err_count;

    fc_rx_framer #(.MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_datak(rx_datak),
        .rx_sync(rx_sync), .out_data(out_data), .out_valid(out_valid),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .out_error(out_error), .r_rdy(r_rdy), .frame_ok_count(frame_ok_count),
        .frame_err_count(frame_err_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- stream-level model ----------------
    logic [31:0] e_data = '0;
    bit          e_valid = 0, e_sop = 0, e_eop = 0, e_err = 0, e_rrdy = 0;
    int          m_ok = 0, m_err = 0;
    string       md = "LOS";
    int          run = 0;
    logic [31:0] hq[$];
    bit          first = 0;
    int          nwords = 0;

    task automatic emit(input logic [31:0] w, input bit eop, input bit er);
        e_valid = 1; e_data = w; e_sop = first; first = 0; e_eop = eop; e_err = er;
    endtask

    task automatic close_frame(input bit good);
        bit had;
        had = hq.size() > 0;
        if (had) emit(hq.pop_front(), 1, !good);
        if (good && had) begin
            if (m_ok < 65535) m_ok++;
        end else begin
            if (m_err < 65535) m_err++;
        end
    endtask

    task automatic model(input logic [31:0] d, input logic [3:0] k, input bit s, input bit r);
        bit os, dat, sof, eof, good, rr;
        e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0; e_rrdy = 0;
        if (r) begin
            md = "LOS"; run = 0; hq.delete(); first = 0; nwords = 0;
            m_ok = 0; m_err = 0; e_data = '0;
            return;
        end
        os   = (k == 4'b0001) && (d[7:0] == 8'hBC);
        dat  = (k == 4'b0000);
        sof  = os && d[15:8] == 8'hB5 && d[23:16] == d[31:24] &&
               (d[23:16] == 8'h56 || d[23:16] == 8'h36 || d[23:16] == 8'h58);
        eof  = os && (d[15:8] == 8'h95 || d[15:8] == 8'hB5) && d[23:16] == d[31:24] &&
               (d[23:16] == 8'h75 || d[23:16] == 8'hD5 || d[23:16] == 8'hF5);
        good = eof && d[23:16] != 8'hF5;
        rr   = os && d == W_RRDY;
        if (!s) begin
            if (md == "FRAME") close_frame(0);
            md = "LOS";
            return;
        end
        if (rr && (md == "IDLE" || md == "FRAME" || md == "DISCARD")) e_rrdy = 1;
        if (md == "LOS") begin
            md = "HUNT"; run = 0;
        end else if (md == "HUNT") begin
            run = os ? run + 1 : 0;
            if (run == 3) md = "IDLE";
        end else if (md == "IDLE") begin
            if (sof) begin md = "FRAME"; first = 1; nwords = 0; end
        end else if (md == "FRAME") begin
            if (dat) begin
                if (nwords == MAXW) begin
                    close_frame(0); md = "DISCARD";
                end else begin
                    if (hq.size() > 0) emit(hq.pop_front(), 0, 0);
                    hq.push_back(d); nwords++;
                end
            end else if (sof) begin
                close_frame(0); first = 1; nwords = 0;
            end else if (eof) begin
                close_frame(good); md = "IDLE";
            end else begin
                close_frame(0); md = "IDLE";
            end
        end else begin
            if (os) md = "IDLE";
        end
    endtask

    // ---------------- compare process ----------------
    logic [31:0] cap_d[$];
    logic [2:0]  cap_f[$];
    int          rr_seen = 0;

    always @(posedge clk) begin
        #2;
        chk("valid", {31'd0, out_valid}, {31'd0, e_valid});
        chk("sop", {31'd0, out_startofpacket}, {31'd0, e_sop});
        chk("eop", {31'd0, out_endofpacket}, {31'd0, e_eop});
        chk("error", {31'd0, out_error}, {31'd0, e_err});
        chk("r_rdy", {31'd0, r_rdy}, {31'd0, e_rrdy});
        chk("ok_count", {16'd0, frame_ok_count}, 32'(m_ok));
        chk("err_count", {16'd0, frame_err_count}, 32'(m_err));
        if (e_valid) chk("data", out_data, e_data);
        if (out_valid) begin
            cap_d.push_back(out_data);
            cap_f.push_back({out_startofpacket, out_endofpacket, out_error});
        end
        if (r_rdy) rr_seen++;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [31:0] d, input logic [3:0] k, input bit s, input bit r);
        @(negedge clk);
        rx_data = d; rx_datak = k; rx_sync = s; reset = r;
        model(d, k, s, r);
    endtask

    task automatic os(input logic [31:0] d);  cyc(d, 4'b0001, 1, 0); endtask
    task automatic dw(input logic [31:0] d);  cyc(d, 4'b0000, 1, 0); endtask

    task automatic clr();
        cap_d.delete(); cap_f.delete(); rr_seen = 0;
    endtask

    initial begin
        cyc(W_IDLE, 4'b0001, 0, 1);
        cyc(W_IDLE, 4'b0001, 0, 1);
        cyc(W_IDLE, 4'b0001, 0, 0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ok", {16'd0, frame_ok_count}, 32'd0);

        // lock: LOS->HUNT then three ordered sets
        repeat (4) os(W_IDLE);

        // basic good frame
        clr();
        os(W_SOF); dw(32'h11111111); dw(32'h22222222); dw(32'h33333333); dw(32'h44444444);
        os(W_EOFT); os(W_IDLE);
        chk("f1_beats", 32'(cap_d.size()), 32'd4);
        chk("f1_d0", cap_d[0], 32'h11111111);
        chk("f1_f0", {29'd0, cap_f[0]}, 32'b100);
        chk("f1_d3", cap_d[3], 32'h44444444);
        chk("f1_f3", {29'd0, cap_f[3]}, 32'b010);
        chk("f1_ok", {16'd0, frame_ok_count}, 32'd1);

        // aborted frame
        clr();
        os(W_SOF); dw(32'h11111111); dw(32'h22222222); dw(32'h33333333); dw(32'h44444444);
        os(W_EOFA); os(W_IDLE);
        chk("f2_f3", {29'd0, cap_f[3]}, 32'b011);
        chk("f2_err", {16'd0, frame_err_count}, 32'd1);

        // SOF inside a frame
        clr();
        os(W_SOF); dw(32'hA1A1A1A1); dw(32'hA2A2A2A2); os(W_SOF); dw(32'hB1B1B1B1);
        os(W_EOFN); os(W_IDLE);
        chk("f3_beats", 32'(cap_d.size()), 32'd3);
        chk("f3_f1", {29'd0, cap_f[1]}, 32'b011);
        chk("f3_f2", {29'd0, cap_f[2]}, 32'b110);
        chk("f3_d2", cap_d[2], 32'hB1B1B1B1);
        chk("f3_ok", {16'd0, frame_ok_count}, 32'd2);
        chk("f3_err", {16'd0, frame_err_count}, 32'd2);

        // SOF immediately followed by EOF
        clr();
        os(W_SOF); os(W_EOFT); os(W_IDLE);
        chk("f4_beats", 32'(cap_d.size()), 32'd0);
        chk("f4_err", {16'd0, frame_err_count}, 32'd3);

        // R_RDY in IDLE, then inside a frame
        clr();
        os(W_RRDY); os(W_IDLE);
        chk("rr_idle", 32'(rr_seen), 32'd1);
        os(W_SOF); dw(32'hC1C1C1C1); os(W_RRDY); os(W_IDLE);
        chk("rr_frame", 32'(rr_seen), 32'd2);
        chk("rr_frame_f", {29'd0, cap_f[0]}, 32'b111);

        // invalid word and unknown ordered set inside a frame
        os(W_SOF); dw(32'hE1E1E1E1); dw(32'hE2E2E2E2); cyc(32'h12345678, 4'b0010, 1, 0);
        os(W_SOF); dw(32'hE3E3E3E3); os(W_OTH); os(W_IDLE);
        chk("inv_err", {16'd0, frame_err_count}, 32'd6);

        // oversize frame
        clr();
        os(W_SOF);
        for (int i = 1; i <= MAXW + 1; i++) dw(32'(i));
        dw(32'hDEADBEEF); os(W_IDLE);
        os(W_SOF); dw(32'h0BADF00D); os(W_EOFT); os(W_IDLE);
        chk("big_beats", 32'(cap_d.size()), 32'd538);
        chk("big_d536", cap_d[536], 32'd537);
        chk("big_f536", {29'd0, cap_f[536]}, 32'b011);
        chk("big_f537", {29'd0, cap_f[537]}, 32'b110);
        chk("big_ok", {16'd0, frame_ok_count}, 32'd3);
        chk("big_err", {16'd0, frame_err_count}, 32'd7);

        // sync loss mid-frame and relock
        clr();
        os(W_SOF); dw(32'hF1F1F1F1); dw(32'hF2F2F2F2);
        cyc(32'hF3F3F3F3, 4'b0000, 0, 0);
        cyc(32'hF4F4F4F4, 4'b0000, 0, 0);
        cyc(W_RRDY, 4'b0001, 0, 0);
        dw(32'h99999999);
        os(W_IDLE); os(W_IDLE); dw(32'h98989898);
        os(W_RRDY); os(W_IDLE); os(W_SOF); dw(32'h97979797);
        os(W_IDLE);
        chk("los_beats", 32'(cap_d.size()), 32'd2);
        chk("los_f1", {29'd0, cap_f[1]}, 32'b011);
        chk("los_rr", 32'(rr_seen), 32'd0);
        chk("los_err", {16'd0, frame_err_count}, 32'd8);
        os(W_SOF); dw(32'h12121212); os(W_EOFT); os(W_IDLE);
        chk("los_ok", {16'd0, frame_ok_count}, 32'd4);

        // reset mid-frame
        clr();
        os(W_SOF); dw(32'h21212121); dw(32'h22222222);
        cyc(32'h23232323, 4'b0000, 1, 1);
        cyc(32'h23232323, 4'b0000, 1, 1);
        cyc(W_EOFT, 4'b0001, 1, 0);
        os(W_IDLE);
        chk("rst_beats", 32'(cap_d.size()), 32'd1);
        chk("rst_f0", {29'd0, cap_f[0]}, 32'b100);
        chk("rst_ok2", {16'd0, frame_ok_count}, 32'd0);
        chk("rst_err2", {16'd0, frame_err_count}, 32'd0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fc_rx_framer.md
FC_RX_FRAMER -- requirements
Module: fc_rx_framer

Interface
REQ-001 SHALL have port clk  in  1  single clock (PHY rx_clk domain); all logic on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port rx_data  in  32  PHY parallel word; byte 0 (bits 7:0) is the first character on the line.
REQ-004 SHALL have port rx_datak  in  4  K-flag per byte; bit n qualifies byte n.
REQ-005 SHALL have port rx_sync  in  1  PHY word sync (all syncstatus bits high).
REQ-006 SHALL have port out_data  out  32  frame word (header, payload, CRC), same byte order as rx_data.
REQ-007 SHALL have ports out_valid, out_startofpacket, out_endofpacket, out_error  out  1 each  Avalon-ST source with no ready signal.
REQ-008 SHALL have port r_rdy  out  1  one-cycle pulse per received R_RDY.
REQ-009 SHALL have ports frame_ok_count, frame_err_count  out  16 each  saturating counters.
REQ-010 SHALL have port MAX_WORDS  parameter  default 537  maximum frame words, SOF and EOF excluded.

Function
REQ-011 SHALL classify each input word as ordered set (OS) when rx_datak==4'b0001 and byte0==8'hBC, data when rx_datak==4'b0000, otherwise invalid.
REQ-012 SHALL decode these OS: IDLE 32'hB5B595BC; R_RDY 32'h4A4A95BC; SOF when byte1==8'hB5 and byte2==byte3 in {8'h56,8'h36,8'h58}; EOF when byte1 in {8'h95,8'hB5} and byte2==byte3 in {8'h75 EOFt, 8'hD5 EOFn, 8'hF5 EOFa}; any other OS is "other OS".
REQ-013 SHALL implement states LOS, HUNT, IDLE, FRAME, DISCARD.
REQ-014 LOS: entered whenever rx_sync==0, from any state; go to HUNT when rx_sync==1.
REQ-015 HUNT: go to IDLE after 3 consecutive OS words; a data or invalid word restarts the count.
REQ-016 IDLE: SOF moves to FRAME; data, EOF, other OS and invalid words are ignored.
REQ-017 FRAME: each data word is held in a one-word register; the previously held word is emitted with out_valid=1, giving 1-cycle latency.
REQ-018 The first emitted word of a frame SHALL have out_startofpacket=1.
REQ-019 EOFt or EOFn in FRAME SHALL emit the held word with out_endofpacket=1 and out_error=0, increment frame_ok_count, and go to IDLE.
REQ-020 EOFa in FRAME SHALL emit the held word with out_endofpacket=1 and out_error=1, increment frame_err_count, and go to IDLE.
REQ-021 An EOF with no held word (SOF immediately followed by EOF) SHALL emit nothing, increment frame_err_count, and go to IDLE.
REQ-022 SOF in FRAME SHALL close the current frame as errored (as REQ-020 if a word is held, else as REQ-021) and restart FRAME for the new frame.
REQ-023 IDLE, R_RDY, other OS or an invalid word in FRAME SHALL close the frame as errored and go to IDLE; R_RDY still pulses r_rdy.
REQ-024 A data word arriving when MAX_WORDS words are already counted SHALL close the frame as errored; remaining words are dropped in DISCARD until EOF or any OS, then the block goes to IDLE.
REQ-025 rx_sync falling in FRAME SHALL close the frame as errored in that cycle, then go to LOS.
REQ-026 r_rdy SHALL pulse 1 cycle after an R_RDY word in any state except LOS and HUNT.
REQ-027 Counters SHALL saturate at 16'hFFFF.
REQ-028 out_startofpacket, out_endofpacket and out_error SHALL be 0 whenever out_valid=0.

Reset
REQ-029 On reset: state LOS, held-word register empty, out_valid/sop/eop/error/r_rdy=0, out_data=0, both counters=0, word count=0.
REQ-030 Reset asserted mid-frame SHALL drop the frame without emitting eop or counting it.

Verification
REQ-031 3xIDLE, SOFi3 32'h5656B5BC, data D0..D3, EOFt 32'h757595BC -> 4 beats; sop on D0, eop on D3, error=0; frame_ok_count=1.
REQ-032 Same frame ended by EOFa 32'hF5F595BC -> eop on D3 with error=1; frame_err_count=1.
REQ-033 SOF, 2 data words, SOF, 1 data word, EOFn -> first frame eop+error on word 2; second frame sop+eop on its single word; ok=1, err=1.
REQ-034 SOF followed by 538 data words -> eop+error on word 537; word 538 dropped; err=1; next SOF frame accepted.
REQ-035 R_RDY 32'h4A4A95BC in IDLE -> one r_rdy pulse; with rx_sync=0 or during HUNT -> no pulse.
REQ-036 rx_sync drops mid-frame -> eop+error on the held word; subsequent data ignored until 3 OS words after rx_sync returns.
